// File: rtl/iter_shifter.sv
// Iterative barrel-free shifter: moves the operand one bit per cycle under a valid/ready handshake.
// Arithmetic right shift is only built when ITER_SHIFTER_ARITH_EN is defined.
module iter_shifter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMTW-1:0]  in_amt,
    input  logic             in_dir,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    count_q, count_d;
    logic             dir_q, dir_d;
    logic             fill_q, fill_d;
    logic             sat_q, sat_d;

    logic             accept;
    logic             amt_sat;
    logic             arith_eff;
    logic [CW-1:0]    amt_count;
    logic [WIDTH-1:0] data_shifted;

`ifdef ITER_SHIFTER_ARITH_EN
    assign arith_eff = in_dir & in_arith;
`else
    logic unused_arith;
    assign unused_arith = in_arith;
    assign arith_eff    = 1'b0;
`endif

    assign accept  = in_valid && in_ready;
    // Compare at a width wide enough for both the amount and WIDTH.
    assign amt_sat   = 64'(in_amt) >= 64'(WIDTH);
    assign amt_count = amt_sat ? CW'(WIDTH) : CW'(in_amt);

    // fill_q is only ever set for arithmetic right shifts, so it doubles as the sign fill.
    assign data_shifted = dir_q ? {fill_q, data_q[WIDTH-1:1]} : {data_q[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (amt_count == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                if (count_q == CW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        out_data  = data_q;
        out_sat   = sat_q;
    end

    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        dir_d   = dir_q;
        fill_d  = fill_q;
        sat_d   = sat_q;
        if (accept) begin
            data_d  = in_data;
            count_d = amt_count;
            dir_d   = in_dir;
            fill_d  = arith_eff & in_data[WIDTH-1];
            sat_d   = amt_sat;
        end else if (state_q == StShift) begin
            data_d  = data_shifted;
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
            sat_q   <= sat_d;
        end
    end

endmodule
